// File: rtl/fetch_unit.sv
// fetch_unit: RV64 fetch stage owning the PC, IF/ID register and end-of-memory halt.
// Define FETCH_PERF_COUNT_EN to add the fetch_count/bubble_count performance counters.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [31:0] out_instruction,
    output logic [63:0] out_pc,
    output logic        out_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [63:0] fetch_count,
    output logic [63:0] bubble_count
`endif
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n, out_pc_n;
    logic [31:0] out_instruction_n;
    logic        out_valid_n, legal, fetch_inc, bubble_inc;

    assign inst_address = pc;
    assign halted       = (state == HALT);
    // Upper-bound check written as pc <= MEM_BYTES-4 so pc near 2^64 cannot wrap into range.
    assign legal        = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
    assign bubble_inc   = (state == RUN) && redirect;
    assign fetch_inc    = (state == RUN) && !redirect && !stall && legal;

    always_comb begin
        state_n           = state;
        pc_n              = pc;
        out_pc_n          = out_pc;
        out_instruction_n = out_instruction;
        out_valid_n       = (state == RUN) ? out_valid : 1'b0;
        if (bubble_inc) begin
            pc_n              = redirect_target;
            out_valid_n       = 1'b0;
            out_instruction_n = NOP;
        end else if (fetch_inc) begin
            pc_n              = pc + 64'd4;
            out_pc_n          = pc;
            out_instruction_n = instruction;
            out_valid_n       = 1'b1;
        end else if (state == RUN && !stall) begin
            state_n     = HALT;
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            pc              <= RESET_PC;
            out_pc          <= 64'd0;
            out_instruction <= NOP;
            out_valid       <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            out_pc          <= out_pc_n;
            out_instruction <= out_instruction_n;
            out_valid       <= out_valid_n;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= 64'd0;
            bubble_count <= 64'd0;
        end else begin
            fetch_count  <= fetch_count + 64'(fetch_inc);
            bubble_count <= bubble_count + 64'(bubble_inc);
        end
    end
`endif
endmodule
